dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Responder (memory side) of the PMIPS data-memory interface. It services the core's MEM-stage accesses (dmemaddr/dmemwdata/dmemwrite/dmemread -> dmemrdata).
- Word RAM with combinational read and clocked write.
- Small memory-mapped I/O block: output port, sampled input port, free-running cycle counter, sticky error status.
- Instantiated beside the core in the top level; the core latches dmemrdata into MEM/WB on the same edge the access is presented.

Parameters:
DEPTH, 256, number of 16-bit RAM words; RAM occupies byte addresses 0 .. 2*DEPTH-1
MMIO_BASE, 16'hFF00, base byte address of the MMIO register block (must exceed 2*DEPTH-1)

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
dmemaddr  input  16  byte address from core; word accesses only
dmemwdata  input  16  write data
dmemwrite  input  1  write enable; commits at posedge clock
dmemread  input  1  read enable
dmemrdata  output  16  read data, combinational from address/state in the same cycle
io_in  input  16  external input port, sampled each cycle
io_out  output  16  external output port register

Behaviour:
Address decode (combinational):
- RAM: dmemaddr < 2*DEPTH; word index = dmemaddr[15:1].
- MMIO offsets:
  - +0 OUT: R/W; drives io_out.
  - +2 IN: read-only; returns io_in_q.
  - +4 CYC: R/W cycle counter.
  - +6 STAT: bit0 = misalign sticky, bit1 = unmapped sticky; other bits read 0.
  - +8 and +10: see Optional Feature.
- Anything else is unmapped.

Misalign and unmapped handling:
- dmemaddr[0]=1 with read or write: misaligned. Read returns 0, write ignored, STAT.bit0 set at next edge.
- Unmapped access, or a write to IN: STAT.bit1 set; read returns 0; write ignored.
- A misaligned access sets only bit0, never bit1.

Read path:
- dmemrdata = selected data when dmemread=1; 16'h0000 when dmemread=0.
- Zero latency: the core samples it at the end of the same cycle.

Write path:
- Write takes effect at the posedge where dmemwrite=1.
- A read of the same address in the same cycle returns the pre-write value.
- dmemread and dmemwrite both high: write performed; dmemrdata shows the pre-write value.

Registers:
- io_in_q <= io_in every cycle, giving exactly 1 cycle of sampling latency.
- CYC increments by 1 each cycle and wraps 16'hFFFF -> 0. A write to CYC loads dmemwdata and wins over the increment; the next cycle reads the written value, the cycle after reads value+1.
- STAT is write-1-to-clear per bit. If a set event and a clear of the same bit occur in one cycle, the set wins.

Reset (synchronous, reset=1 at posedge):
- io_out=0, io_in_q=0, CYC=0, STAT=0.
- RAM contents not cleared; they hold their values across reset.
- Accesses presented during a reset cycle are ignored: no write, no flag set.
- dmemrdata is combinational and remains valid during reset.

RAM contents are undefined until written; the bench must write before reading.

Optional Feature:
DMEM_ACCESS_COUNT_EN
- Defined:
  - MMIO_BASE+8 RDCNT counts accepted aligned, mapped reads.
  - MMIO_BASE+10 WRCNT counts accepted aligned, mapped writes.
  - Both are 16-bit, wrap to 0, reset to 0, read-only.
  - A write to either clears both counters; that write is not itself counted and does not set STAT.bit1.
  - Reads of the counters are counted, and the returned value is the pre-increment value.
- Undefined: +8 and +10 are unmapped (read 0, set STAT.bit1). No counter flops are synthesized.

Test Plan:
- RAM write/read: write 16'hBEEF to 0x0010, then read 0x0010 next cycle -> dmemrdata=16'hBEEF; dmemread=0 the cycle after -> dmemrdata=0.
- Same-cycle read+write of 0x0020 (old 16'h1111, new 16'h2222): dmemrdata=16'h1111 in that cycle; 16'h2222 on the next read.
- Misalign: write 16'h5555 to 0x0011 -> RAM word 0x0010 unchanged and STAT reads 16'h0001. Write 16'h0001 to STAT -> STAT=0. Read 0x0200 with DEPTH=256 -> dmemrdata=0 and STAT=16'h0002.
- CYC: write 16'hFFFE at cycle N -> read 16'hFFFE at N+1, 16'hFFFF at N+2, 16'h0000 at N+3.
- IO: write 16'h00A5 to MMIO_BASE -> io_out=16'h00A5 after the edge. Drive io_in=16'h1234 at cycle K -> read of MMIO_BASE+2 returns 16'h1234 from K+1.
- Reset mid-operation: io_out=16'h00A5, CYC=100, STAT=3, then assert reset with a concurrent write to MMIO_BASE -> all read 0 afterwards, RAM data retained, write dropped. With DMEM_ACCESS_COUNT_EN: 3 RAM reads -> RDCNT reads 3 (that read of RDCNT is then counted as a 4th).

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder -- memory-side responder for the PMIPS data-memory interface.
//
// Services the core's MEM-stage word accesses. Holds a word RAM (combinational
// read, clocked write) and a small MMIO block at MMIO_BASE:
//   +0  OUT    R/W, drives io_out
//   +2  IN     read-only, io_in sampled one cycle earlier
//   +4  CYC    R/W free-running cycle counter (a write wins over the increment)
//   +6  STAT   bit0 misalign sticky, bit1 unmapped sticky, write-1-to-clear
//   +8  RDCNT  read-only access counter   (only with DMEM_ACCESS_COUNT_EN)
//   +10 WRCNT  read-only access counter   (only with DMEM_ACCESS_COUNT_EN)
//
// Optional feature macro: DMEM_ACCESS_COUNT_EN. When it is undefined, +8/+10
// decode as unmapped and no counter flops exist.
//
// Ports:
//   clock      system clock, all state updates on posedge
//   reset      synchronous active-high reset
//   dmemaddr   byte address (word accesses only)
//   dmemwdata  write data
//   dmemwrite  write enable, commits at posedge
//   dmemread   read enable
//   dmemrdata  combinational read data (0 when dmemread=0)
//   io_in      external input port
//   io_out     external output port register
module dmem_responder #(
  parameter int          DEPTH     = 256,
  parameter logic [15:0] MMIO_BASE = 16'hFF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] dmemaddr,
  input  logic [15:0] dmemwdata,
  input  logic        dmemwrite,
  input  logic        dmemread,
  output logic [15:0] dmemrdata,
  input  logic [15:0] io_in,
  output logic [15:0] io_out
);

  localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] RAM_BYTES = 17'(2 * DEPTH);
  localparam logic [15:0] A_OUT     = MMIO_BASE;
  localparam logic [15:0] A_IN      = MMIO_BASE + 16'd2;
  localparam logic [15:0] A_CYC     = MMIO_BASE + 16'd4;
  localparam logic [15:0] A_STAT    = MMIO_BASE + 16'd6;

  logic [15:0] r_mem [DEPTH];
  logic [15:0] r_io_out;
  logic [15:0] r_io_in_q;
  logic [15:0] r_cyc;
  logic [1:0]  r_stat;

  logic [IDX_W-1:0] w_idx;
  logic        w_acc;
  logic        w_mis;
  logic        w_hit_ram;
  logic        w_hit_out;
  logic        w_hit_in;
  logic        w_hit_cyc;
  logic        w_hit_stat;
  logic        w_hit_cnt;
  logic        w_mapped;
  logic        w_set_mis;
  logic        w_set_unm;
  logic [1:0]  w_stat_clr;
  logic [15:0] w_rdata;

  assign w_idx = dmemaddr[IDX_W:1];
  assign w_acc = dmemread | dmemwrite;
  assign w_mis = dmemaddr[0];

  // All hits are qualified by alignment so a misaligned access never looks
  // mapped and therefore only ever raises the misalign flag.
  assign w_hit_ram  = !w_mis && ({1'b0, dmemaddr} < RAM_BYTES);
  assign w_hit_out  = !w_mis && (dmemaddr == A_OUT);
  assign w_hit_in   = !w_mis && (dmemaddr == A_IN);
  assign w_hit_cyc  = !w_mis && (dmemaddr == A_CYC);
  assign w_hit_stat = !w_mis && (dmemaddr == A_STAT);

`ifdef DMEM_ACCESS_COUNT_EN
  localparam logic [15:0] A_RDCNT = MMIO_BASE + 16'd8;
  localparam logic [15:0] A_WRCNT = MMIO_BASE + 16'd10;

  logic [15:0] r_rdcnt;
  logic [15:0] r_wrcnt;
  logic        w_hit_rdcnt;
  logic        w_hit_wrcnt;
  logic        w_rd_acc;
  logic        w_wr_acc;
  logic        w_cnt_clr;

  assign w_hit_rdcnt = !w_mis && (dmemaddr == A_RDCNT);
  assign w_hit_wrcnt = !w_mis && (dmemaddr == A_WRCNT);
  assign w_hit_cnt   = w_hit_rdcnt | w_hit_wrcnt;
`else
  assign w_hit_cnt   = 1'b0;
`endif

  assign w_mapped = w_hit_ram | w_hit_out | w_hit_in | w_hit_cyc |
                    w_hit_stat | w_hit_cnt;

  // Error events. A write to the read-only IN register counts as unmapped.
  assign w_set_mis  = w_acc && w_mis;
  assign w_set_unm  = (w_acc && !w_mis && !w_mapped) || (dmemwrite && w_hit_in);
  assign w_stat_clr = (dmemwrite && w_hit_stat) ? dmemwdata[1:0] : 2'b00;

  // Zero-latency read mux; reflects pre-write state when read and write coincide.
  always_comb begin
    w_rdata = 16'h0000;
    if (dmemread) begin
      if (w_hit_ram)       w_rdata = r_mem[w_idx];
      else if (w_hit_out)  w_rdata = r_io_out;
      else if (w_hit_in)   w_rdata = r_io_in_q;
      else if (w_hit_cyc)  w_rdata = r_cyc;
      else if (w_hit_stat) w_rdata = {14'd0, r_stat};
`ifdef DMEM_ACCESS_COUNT_EN
      else if (w_hit_rdcnt) w_rdata = r_rdcnt;
      else if (w_hit_wrcnt) w_rdata = r_wrcnt;
`endif
    end
  end

  assign dmemrdata = w_rdata;
  assign io_out    = r_io_out;

  // RAM contents survive reset; reset only blocks the write.
  always_ff @(posedge clock) begin
    if (!reset && dmemwrite && w_hit_ram) r_mem[w_idx] <= dmemwdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_io_out  <= 16'h0000;
      r_io_in_q <= 16'h0000;
      r_cyc     <= 16'h0000;
      r_stat    <= 2'b00;
    end else begin
      r_io_in_q <= io_in;
      if (dmemwrite && w_hit_out) r_io_out <= dmemwdata;
      r_cyc <= (dmemwrite && w_hit_cyc) ? dmemwdata : r_cyc + 16'd1;
      // Set is OR-ed in after the clear so a same-cycle set wins.
      r_stat <= (r_stat & ~w_stat_clr) | {w_set_unm, w_set_mis};
    end
  end

`ifdef DMEM_ACCESS_COUNT_EN
  assign w_rd_acc  = dmemread && w_mapped;
  assign w_wr_acc  = dmemwrite && w_mapped && !w_hit_in && !w_hit_cnt;
  assign w_cnt_clr = dmemwrite && w_hit_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdcnt <= 16'h0000;
      r_wrcnt <= 16'h0000;
    end else if (w_cnt_clr) begin
      r_rdcnt <= 16'h0000;
      r_wrcnt <= 16'h0000;
    end else begin
      if (w_rd_acc) r_rdcnt <= r_rdcnt + 16'd1;
      if (w_wr_acc) r_wrcnt <= r_wrcnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder -- directed self-checking bench for dmem_responder.
// Each access pushes its expected read data to a scoreboard queue; the value
// is popped and compared against dmemrdata mid-cycle, before the write edge.
module tb_dmem_responder;

  localparam logic [15:0] MB     = 16'hFF00;
  localparam logic [15:0] A_OUT  = MB;
  localparam logic [15:0] A_IN   = MB + 16'd2;
  localparam logic [15:0] A_CYC  = MB + 16'd4;
  localparam logic [15:0] A_STAT = MB + 16'd6;
  localparam logic [15:0] A_RDC  = MB + 16'd8;
  localparam logic [15:0] A_WRC  = MB + 16'd10;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] dmemaddr;
  logic [15:0] dmemwdata;
  logic        dmemwrite;
  logic        dmemread;
  logic [15:0] dmemrdata;
  logic [15:0] io_in;
  logic [15:0] io_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] q_exp [$];
  string       q_tag [$];

  dmem_responder #(.DEPTH(256), .MMIO_BASE(MB)) dut (
    .clock     (clock),
    .reset     (reset),
    .dmemaddr  (dmemaddr),
    .dmemwdata (dmemwdata),
    .dmemwrite (dmemwrite),
    .dmemread  (dmemread),
    .dmemrdata (dmemrdata),
    .io_in     (io_in),
    .io_out    (io_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle, entered and left at a negedge.
  task automatic access(input logic [15:0] addr, input logic [15:0] wdata,
                        input logic we, input logic re,
                        input logic [15:0] exp, input string tag);
    logic [15:0] e;
    string       t;
    dmemaddr  = addr;
    dmemwdata = wdata;
    dmemwrite = we;
    dmemread  = re;
    q_exp.push_back(exp);
    q_tag.push_back(tag);
    #1;
    e = q_exp.pop_front();
    t = q_tag.pop_front();
    check(t, dmemrdata, e);
    @(posedge clock);
    @(negedge clock);
    dmemwrite = 1'b0;
    dmemread  = 1'b0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data, input string tag);
    access(addr, data, 1'b1, 1'b0, 16'h0000, tag);
  endtask

  task automatic rd(input logic [15:0] addr, input logic [15:0] exp, input string tag);
    access(addr, 16'h0000, 1'b0, 1'b1, exp, tag);
  endtask

  initial begin
    reset     = 1'b1;
    dmemaddr  = 16'h0000;
    dmemwdata = 16'h0000;
    dmemwrite = 1'b0;
    dmemread  = 1'b0;
    io_in     = 16'h0000;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset state
    check("rst_io_out", io_out, 16'h0000);
    rd(A_CYC,  16'h0000, "rst_cyc");
    rd(A_OUT,  16'h0000, "rst_out");
    rd(A_STAT, 16'h0000, "rst_stat");
    rd(A_IN,   16'h0000, "rst_in");

    // RAM write then read, then idle read port
    wr(16'h0010, 16'hBEEF, "ram_wr");
    rd(16'h0010, 16'hBEEF, "ram_rd");
    access(16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, "ram_rd_idle");

    // Same-cycle read and write returns the old value
    wr(16'h0020, 16'h1111, "rw_init");
    access(16'h0020, 16'h2222, 1'b1, 1'b1, 16'h1111, "rw_same");
    rd(16'h0020, 16'h2222, "rw_after");

    // Misalign / unmapped / write to IN
    wr(16'h0011, 16'h5555, "mis_wr");
    rd(16'h0010, 16'hBEEF, "mis_ram_kept");
    rd(A_STAT,   16'h0001, "mis_stat");
    wr(A_STAT,   16'h0001, "stat_clr0");
    rd(A_STAT,   16'h0000, "stat_cleared");
    rd(16'h0200, 16'h0000, "unm_rd");
    rd(A_STAT,   16'h0002, "unm_stat");
    wr(A_STAT,   16'h0003, "stat_clr_all");
    wr(A_IN,     16'hDEAD, "in_wr");
    rd(A_STAT,   16'h0002, "in_wr_stat");
    wr(A_STAT,   16'h0002, "stat_clr1");
    rd(16'hFF01, 16'h0000, "mis_mmio_rd");
    rd(A_STAT,   16'h0001, "mis_mmio_stat");
    wr(A_STAT,   16'h0001, "stat_clr0b");

    // Cycle counter load and wrap
    wr(A_CYC, 16'hFFFE, "cyc_wr");
    rd(A_CYC, 16'hFFFE, "cyc_n1");
    rd(A_CYC, 16'hFFFF, "cyc_n2");
    rd(A_CYC, 16'h0000, "cyc_n3");

    // IO ports
    wr(A_OUT, 16'h00A5, "out_wr");
    check("io_out_a5", io_out, 16'h00A5);
    rd(A_OUT, 16'h00A5, "out_rd");
    io_in = 16'h1234;
    rd(A_IN, 16'h0000, "in_k");
    rd(A_IN, 16'h1234, "in_k1");

`ifndef DMEM_ACCESS_COUNT_EN
    // Counter offsets decode as unmapped
    rd(A_RDC,  16'h0000, "rdcnt_unm");
    rd(A_STAT, 16'h0002, "rdcnt_unm_stat");
    wr(A_STAT, 16'h0002, "stat_clr1b");
`endif

    // Reset mid-operation
    rd(16'h0011, 16'h0000, "pre_mis");
    rd(16'h0300, 16'h0000, "pre_unm");
    wr(A_CYC, 16'd100, "pre_cyc_wr");
    rd(A_CYC,  16'd100,  "pre_cyc");
    rd(A_STAT, 16'h0003, "pre_stat");
    reset = 1'b1;
    access(A_OUT, 16'h0077, 1'b1, 1'b0, 16'h0000, "rst_wr");
    rd(16'h0010, 16'hBEEF, "rst_rd_valid");
    reset = 1'b0;
    check("post_io_out", io_out, 16'h0000);
    rd(A_CYC,    16'h0000, "post_cyc");
    rd(A_OUT,    16'h0000, "post_out");
    rd(A_STAT,   16'h0000, "post_stat");
    rd(16'h0010, 16'hBEEF, "post_ram10");
    rd(16'h0020, 16'h2222, "post_ram20");

`ifdef DMEM_ACCESS_COUNT_EN
    wr(A_RDC, 16'hFFFF, "cnt_clr");
    rd(16'h0010, 16'hBEEF, "cnt_rd1");
    rd(16'h0020, 16'h2222, "cnt_rd2");
    rd(16'h0010, 16'hBEEF, "cnt_rd3");
    rd(A_RDC, 16'd3, "rdcnt3");
    rd(A_RDC, 16'd4, "rdcnt4");
    wr(16'h0030, 16'hCAFE, "cnt_wr");
    rd(A_WRC,  16'd1,     "wrcnt1");
    rd(A_STAT, 16'h0000, "cnt_stat");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
